router_fifo: RTL and testbench
==============================

Name: router_fifo

Overview:
- 16-deep × 9-bit synchronous FIFO. One instance sits on each output port of the 1x3 packet router.
- Each entry stores one 8-bit packet byte plus a 1-bit header tag, taken from lfd_state at write time.
- The read side tracks packet length from the header byte.
- d_out goes high-impedance once a complete packet (header, payload, parity) has been drained.
- A synchronous soft_reset flushes the FIFO, e.g. on a read-side timeout.

Parameters:
- DEPTH, 16, number of entries (power of two)
- WIDTH, 8, data byte width; stored word is WIDTH+1 bits (MSB = header tag)
- PTR_W, 5, pointer width = log2(DEPTH)+1 (extra wrap bit)

Ports:
- clk  input  1  system clock, rising-edge
- resetn  input  1  asynchronous reset, asserted HIGH (the name is kept for codebase consistency)
- soft_reset  input  1  synchronous flush, active-high
- w_en  input  1  write enable
- r_en  input  1  read enable
- lfd_state  input  1  high while d_in carries the header byte; stored as tag bit 8
- d_in  input  8  packet byte to write
- d_out  output  8  registered read data; high-Z between packets
- empty  output  1  FIFO holds no entries
- full  output  1  FIFO holds DEPTH entries

Behaviour:
Interface:
- One clock; reset is asynchronous and active-high.

Reset (resetn=1, asynchronous):
- Pointers and count are 0; empty=1, full=0.
- d_out=8'h00.
- All memory entries are cleared to 0.

Soft reset (soft_reset=1 at a rising edge, resetn=0):
- Pointers, count and memory are cleared; empty=1, full=0.
- d_out=8'hZZ.
- soft_reset has priority over w_en and r_en in the same cycle.

Pointers and flags:
- 5-bit wr_ptr and rd_ptr; the low 4 bits address memory.
- empty = (wr_ptr == rd_ptr).
- full = (wr_ptr[4] != rd_ptr[4]) && (wr_ptr[3:0] == rd_ptr[3:0]).
- Flags are combinational from the pointers, so they update in the same cycle as a pointer change.

Write:
- When w_en && !full at the rising edge: mem[wr_ptr] <= {lfd_state, d_in}; wr_ptr increments, wrapping modulo 32.
- A write while full is ignored; memory and pointer are unchanged.

Read:
- When r_en && !empty at the rising edge: d_out <= mem[rd_ptr][7:0]; rd_ptr increments.
- Read latency is 1 clock; d_out holds its value on cycles with no read.
- A read while empty is ignored (but see the high-Z rule below).

Simultaneous read and write:
- Both are evaluated against the pre-edge flags.
- When empty, only the write occurs. When full, only the read occurs. Otherwise both occur.

Packet counter (6-bit, reset 0):
- On a read whose entry has tag=1 (header): counter <= d_in_header[7:2] + 1, i.e. payload length plus parity.
- On any other successful read with counter != 0: counter decrements by 1.

High-Z rule:
- On a rising edge where counter==0 and no header read occurs, d_out <= 8'hZZ.
- This applies after the parity byte has been output, and also while idle after a prior packet.
- It does not apply before the first packet after hard reset, when d_out stays 8'h00.

Resets mid-operation:
- resetn overrides everything immediately.
- soft_reset mid-packet discards the remaining bytes and the counter value.

Test Plan:
- Hard reset: resetn=1 pulse → empty=1, full=0, d_out=8'h00 immediately, with no clock needed.
- Fill: after reset, write header 8'h39 (len 14, addr 01) with lfd_state=1, then 14 random payload bytes and 1 parity byte with lfd_state=0.
  - full=1 after the 16th write; empty drops after the 1st write.
  - A 17th write is ignored.
- Drain: w_en=0, r_en=1 for 17+ cycles.
  - d_out = 39, then the 14 payloads, then parity, in write order, each one clock after its read edge.
  - full drops after the first read; empty=1 after the 16th read.
  - d_out=8'hZZ on the edge after parity is output.
- Soft reset: assert soft_reset for one clock with 5 entries stored → empty=1, full=0, d_out=ZZ. A subsequent write/read of 8'h0D returns 8'h0D.
- Concurrent: with 8 entries stored, w_en=r_en=1 for 10 cycles → occupancy stays 8, output order is preserved, and flags never toggle.
- Boundary: with the FIFO empty, w_en=r_en=1 → only the write occurs and d_out is unchanged. With the FIFO full, w_en=r_en=1 → only the read occurs and full drops.

Source files
------------

// File: rtl/router_fifo.sv
// -----------------------------------------------------------------------------
// router_fifo
// 16-deep x 9-bit synchronous FIFO. One instance sits on each output port of
// the 1x3 packet router. Each entry holds a packet byte plus a header tag
// (captured from lfd_state at write time). The read side tracks packet length
// from the header byte and floats d_out once a whole packet has been drained.
//
// Ports:
//   clk         rising-edge system clock
//   resetn      asynchronous reset, asserted HIGH (name kept for codebase
//               consistency)
//   soft_reset  synchronous flush, active-high, wins over w_en / r_en
//   w_en        write enable (ignored while full)
//   r_en        read enable (ignored while empty)
//   lfd_state   high while d_in carries the header byte; stored as tag bit
//   d_in        packet byte to write
//   d_out       registered read data, one clock after the read edge;
//               high-Z between packets
//   empty       FIFO holds no entries (combinational from pointers)
//   full        FIFO holds DEPTH entries (combinational from pointers)
// -----------------------------------------------------------------------------
module router_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int PTR_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             w_en,
    input  logic             r_en,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic             empty,
    output logic             full
);

    // Memory address width; the pointers carry one extra wrap bit.
    localparam int AW    = PTR_W - 1;
    // Packet counter width: header[7:2] is the payload length field.
    localparam int CNT_W = WIDTH - 2;

    logic [WIDTH:0]     mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [WIDTH-1:0]   dout_r;
    logic               hiz_r;
    logic [CNT_W-1:0]   pkt_cnt_r;
    logic               pkt_seen_r;

    logic               empty_s;
    logic               full_s;
    logic               wr_fire_s;
    logic               rd_fire_s;
    logic [WIDTH:0]     rd_word_s;
    logic               hdr_rd_s;
    logic [CNT_W-1:0]   hdr_len_s;
    logic               go_hiz_s;

    // Flags, handshake qualification and packet-tracking decode.
    always_comb begin
        empty_s   = 1'b0;
        full_s    = 1'b0;
        wr_fire_s = 1'b0;
        rd_fire_s = 1'b0;
        rd_word_s = mem_r[rd_ptr_r[AW-1:0]];
        hdr_rd_s  = 1'b0;
        hdr_len_s = rd_word_s[WIDTH-1:2] + CNT_W'(1);
        go_hiz_s  = 1'b0;

        if (wr_ptr_r == rd_ptr_r) begin
            empty_s = 1'b1;
        end else begin
            empty_s = 1'b0;
        end

        // Same slot, opposite lap: the writer is a full lap ahead.
        if ((wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
            (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0])) begin
            full_s = 1'b1;
        end else begin
            full_s = 1'b0;
        end

        wr_fire_s = w_en && !full_s;
        rd_fire_s = r_en && !empty_s;
        hdr_rd_s  = rd_fire_s && rd_word_s[WIDTH];

        // Float the bus once a packet has completed (counter exhausted), but
        // never before the first header seen since hard reset so the bus
        // reads 00 out of reset.
        if (pkt_seen_r && (pkt_cnt_r == {CNT_W{1'b0}}) && !hdr_rd_s) begin
            go_hiz_s = 1'b1;
        end else begin
            go_hiz_s = 1'b0;
        end
    end

    assign empty = empty_s;
    assign full  = full_s;
    assign d_out = hiz_r ? {WIDTH{1'bz}} : dout_r;

    // Storage array: cleared by either reset, written on a qualified write.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {(WIDTH+1){1'b0}};
            end
        end else if (soft_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {(WIDTH+1){1'b0}};
            end
        end else if (wr_fire_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {lfd_state, d_in};
        end else begin
            mem_r <= mem_r;
        end
    end

    // Read/write pointers, each advancing on its own qualified strobe.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else if (soft_reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (wr_fire_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_fire_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Output register, high-Z control and packet length counter.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            dout_r     <= {WIDTH{1'b0}};
            hiz_r      <= 1'b0;
            pkt_cnt_r  <= {CNT_W{1'b0}};
            pkt_seen_r <= 1'b0;
        end else if (soft_reset) begin
            // Drop whatever is left of the current packet and float the bus.
            dout_r     <= {WIDTH{1'b0}};
            hiz_r      <= 1'b1;
            pkt_cnt_r  <= {CNT_W{1'b0}};
            pkt_seen_r <= pkt_seen_r;
        end else begin
            if (go_hiz_s) begin
                dout_r <= dout_r;
                hiz_r  <= 1'b1;
            end else if (rd_fire_s) begin
                dout_r <= rd_word_s[WIDTH-1:0];
                hiz_r  <= 1'b0;
            end else begin
                dout_r <= dout_r;
                hiz_r  <= hiz_r;
            end

            // Header loads payload length + parity; every later read counts down.
            if (hdr_rd_s) begin
                pkt_cnt_r <= hdr_len_s;
            end else if (rd_fire_s && (pkt_cnt_r != {CNT_W{1'b0}})) begin
                pkt_cnt_r <= pkt_cnt_r - CNT_W'(1);
            end else begin
                pkt_cnt_r <= pkt_cnt_r;
            end

            if (hdr_rd_s) begin
                pkt_seen_r <= 1'b1;
            end else begin
                pkt_seen_r <= pkt_seen_r;
            end
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// -----------------------------------------------------------------------------
// tb_router_fifo
// Self-checking bench for router_fifo. A queue-based reference model applies
// the FIFO / packet-length / high-Z rules each clock; directed phases cover
// reset, fill, drain, soft reset, concurrent traffic and the empty/full
// boundaries, followed by a randomized traffic phase.
// -----------------------------------------------------------------------------
module tb_router_fifo;

    localparam int DEPTH = 16;

    logic       clk;
    logic       resetn;
    logic       soft_reset;
    logic       w_en;
    logic       r_en;
    logic       lfd_state;
    logic [7:0] d_in;
    wire  [7:0] d_out;
    wire        empty;
    wire        full;

    int total;
    int bad;

    // Reference model state
    logic [8:0] q[$];
    logic [5:0] m_cnt;
    logic       m_seen;
    logic [7:0] m_dout;

    router_fifo #(.DEPTH(16), .WIDTH(8), .PTR_W(5)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .w_en       (w_en),
        .r_en       (r_en),
        .lfd_state  (lfd_state),
        .d_in       (d_in),
        .d_out      (d_out),
        .empty      (empty),
        .full       (full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_empty"}, {7'd0, empty}, {7'd0, (q.size() == 0)});
        chk({tag, "_full"},  {7'd0, full},  {7'd0, (q.size() == DEPTH)});
        chk({tag, "_dout"},  d_out, m_dout);
    endtask

    // Apply one clock's worth of inputs, advance the model, check after the edge.
    task automatic step(input string tag, input logic w, input logic r,
                        input logic l, input logic [7:0] d, input logic s);
        logic       was_empty;
        logic       was_full;
        logic       rd;
        logic       wr;
        logic       hdr;
        logic [5:0] cnt0;
        logic [8:0] word;
        w_en = w; r_en = r; lfd_state = l; d_in = d; soft_reset = s;
        if (s) begin
            q.delete();
            m_cnt  = 6'd0;
            m_dout = 8'hzz;
        end else begin
            was_empty = (q.size() == 0);
            was_full  = (q.size() == DEPTH);
            rd   = r && !was_empty;
            wr   = w && !was_full;
            hdr  = 1'b0;
            cnt0 = m_cnt;
            if (rd) begin
                word   = q.pop_front();
                hdr    = word[8];
                m_dout = word[7:0];
                if (hdr) m_cnt = word[7:2] + 6'd1;
                else if (m_cnt != 6'd0) m_cnt = m_cnt - 6'd1;
            end
            if (m_seen && (cnt0 == 6'd0) && !hdr) m_dout = 8'hzz;
            if (hdr) m_seen = 1'b1;
            if (wr) q.push_back({l, d});
        end
        @(posedge clk);
        #1;
        soft_reset = 1'b0;
        chk_all(tag);
    endtask

    // Asynchronous reset pulse between clock edges; checked before any edge.
    task automatic hard_reset(input string tag);
        #2;
        resetn = 1'b1;
        q.delete();
        m_cnt  = 6'd0;
        m_seen = 1'b0;
        m_dout = 8'h00;
        #1;
        chk_all(tag);
        @(posedge clk);
        #1;
        resetn = 1'b0;
    endtask

    initial begin
        logic [7:0] prev;
        total = 0; bad = 0;
        resetn = 1'b0; soft_reset = 1'b0; w_en = 1'b0; r_en = 1'b0;
        lfd_state = 1'b0; d_in = 8'h00;
        m_cnt = 6'd0; m_seen = 1'b0; m_dout = 8'h00;

        // Reset state, observed before the first clock edge
        hard_reset("reset");
        chk("reset_dout_const", d_out, 8'h00);

        // Fill: header 0x39 (14 payload bytes), payload, parity, then a 17th write
        step("fill_hdr", 1'b1, 1'b0, 1'b1, 8'h39, 1'b0);
        for (int i = 0; i < 15; i++) step("fill", 1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0);
        chk("fill_full", {7'd0, full}, 8'h01);
        step("fill_17th", 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0);

        // Drain 18 cycles: header, payload, parity, then high-Z
        step("drain_hdr", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("drain_hdr_byte", d_out, 8'h39);
        for (int i = 0; i < 17; i++) step("drain", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Soft reset with 5 stored entries, then a 0x0D header round-trip
        step("sr_hdr", 1'b1, 1'b0, 1'b1, 8'h20, 1'b0);
        for (int i = 0; i < 4; i++) step("sr_fill", 1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0);
        step("soft_reset", 1'b1, 1'b1, 1'b0, 8'h77, 1'b1);
        step("sr_wr0d", 1'b1, 1'b0, 1'b1, 8'h0D, 1'b0);
        step("sr_rd0d", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("sr_rd0d_byte", d_out, 8'h0D);
        for (int i = 0; i < 4; i++) step("sr_tail", 1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0);
        for (int i = 0; i < 5; i++) step("sr_drain", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Concurrent: 8 stored (long header), then 10 cycles of read+write
        step("cc_hdr", 1'b1, 1'b0, 1'b1, 8'hF8, 1'b0);
        for (int i = 0; i < 7; i++) step("cc_fill", 1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0);
        for (int i = 0; i < 10; i++) step("cc_rw", 1'b1, 1'b1, 1'b0, 8'($urandom), 1'b0);

        // Empty boundary: drain, then read+write while empty writes only
        for (int i = 0; i < 8; i++) step("eb_drain", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        prev = m_dout;
        step("eb_rw", 1'b1, 1'b1, 1'b0, 8'h5A, 1'b0);
        chk("eb_rw_dout_held", d_out, prev);

        // Full boundary: fill up, then read+write while full reads only
        for (int i = 0; i < 15; i++) step("fb_fill", 1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0);
        step("fb_rw", 1'b1, 1'b1, 1'b0, 8'hC3, 1'b0);
        chk("fb_rw_full_drop", {7'd0, full}, 8'h00);
        chk("fb_rw_dout", d_out, 8'h5A);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), 8'($urandom),
                 ($urandom_range(0, 63) == 0));
        end

        // Hard reset mid-operation returns d_out to 00 immediately
        hard_reset("mid_reset");
        step("post_reset_idle", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
